// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit saturating-counter BHT plus direct-mapped BTB,
// with execute-side mispredict detection, redirect generation and a post-reset init sweep.
module branch_predictor #(
   parameter int IDX_BITS = 6,
   parameter int TAG_BITS = 30 - IDX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic        ready,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispredict_cnt
);

   localparam int ENTRIES = 1 << IDX_BITS;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic [31:0]         branch_cnt_q, branch_cnt_d;
   logic [31:0]         mispredict_cnt_q, mispredict_cnt_d;

   logic [1:0]          ctr_q [ENTRIES];
   logic                vld_q [ENTRIES];
   logic [TAG_BITS-1:0] tag_q [ENTRIES];
   logic [31:0]         tgt_q [ENTRIES];

   // Single shared write port into the tables, used by both the sweep and training.
   logic                wr_idx_we;
   logic [IDX_BITS-1:0] wr_idx;
   logic [1:0]          wr_ctr;
   logic                wr_vld_we;
   logic                wr_vld;
   logic                wr_btb_we;

   logic [IDX_BITS-1:0] f_idx;
   logic [TAG_BITS-1:0] f_tag;
   logic                f_hit;
   logic [31:0]         fetch_pc_plus4;

   logic [IDX_BITS-1:0] ex_idx;
   logic [TAG_BITS-1:0] ex_tag;
   logic [31:0]         ex_pc_plus4;
   logic                resolving;
   logic [1:0]          ex_ctr;

   assign ready          = (state_q == ST_RUN);
   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

   assign f_idx          = fetch_pc[IDX_BITS+1:2];
   assign f_tag          = fetch_pc[31:IDX_BITS+2];
   assign fetch_pc_plus4 = fetch_pc + 32'd4;

   assign ex_idx         = ex_pc[IDX_BITS+1:2];
   assign ex_tag         = ex_pc[31:IDX_BITS+2];
   assign ex_pc_plus4    = ex_pc + 32'd4;
   assign ex_ctr         = ctr_q[ex_idx];

   // Lookup reads only registered table state, so same-cycle training is not bypassed.
   always_comb begin
      f_hit       = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
      pred_taken  = ready && f_hit && ctr_q[f_idx][1];
      pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc_plus4;
   end

   always_comb begin
      resolving   = ready && ex_valid && ex_is_branch;
      mispredict  = resolving &&
                    ((ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && (ex_pred_target != ex_target)));
      redirect_pc = (resolving && ex_taken) ? ex_target : ex_pc_plus4;
   end

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      wr_idx_we        = 1'b0;
      wr_idx           = ex_idx;
      wr_ctr           = 2'b01;
      wr_vld_we        = 1'b0;
      wr_vld           = 1'b0;
      wr_btb_we        = 1'b0;

      if (rst) begin
         state_d          = ST_INIT;
         idx_d            = '0;
         branch_cnt_d     = 32'd0;
         mispredict_cnt_d = 32'd0;
      end else if (state_q == ST_INIT) begin
         wr_idx_we = 1'b1;
         wr_idx    = idx_q;
         wr_ctr    = 2'b01;
         wr_vld_we = 1'b1;
         wr_vld    = 1'b0;
         idx_d     = idx_q + {{(IDX_BITS-1){1'b0}}, 1'b1};
         if (idx_q == {IDX_BITS{1'b1}}) begin
            state_d = ST_RUN;
         end
      end else if (resolving) begin
         wr_idx_we = 1'b1;
         wr_idx    = ex_idx;
         if (ex_taken) begin
            wr_ctr = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
         end else begin
            wr_ctr = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
         end
         wr_vld_we        = ex_taken;
         wr_vld           = 1'b1;
         wr_btb_we        = ex_taken;
         branch_cnt_d     = branch_cnt_q + 32'd1;
         mispredict_cnt_d = mispredict_cnt_q + {31'd0, mispredict};
      end
   end

   always_ff @(posedge clk) begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
   end

   // Tables carry no reset; the init sweep is what puts them in a known state.
   always_ff @(posedge clk) begin
      if (wr_idx_we) begin
         ctr_q[wr_idx] <= wr_ctr;
      end
      if (wr_vld_we) begin
         vld_q[wr_idx] <= wr_vld;
      end
      if (wr_btb_we) begin
         tag_q[wr_idx] <= ex_tag;
         tgt_q[wr_idx] <= ex_target;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vectors, a table-level reference model
// compared every cycle, and hand-computed literal expectations.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        ready;
   logic [31:0] branch_cnt;
   logic [31:0] mispredict_cnt;

   branch_predictor dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_pc       (fetch_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .ready          (ready),
      .branch_cnt     (branch_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   // Scoreboard counters
   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: whole-table view, ready after 64 clean cycles since reset
   localparam int ENT = 64;
   int          m_ctr [ENT];
   bit          m_vld [ENT];
   logic [31:0] m_tag [ENT];
   logic [31:0] m_tgt [ENT];
   bit          m_ready   = 0;
   bit          m_started = 0;
   int          m_since_rst = 0;
   logic [31:0] m_bcnt = 0;
   logic [31:0] m_mcnt = 0;

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) % ENT);
   endfunction

   function automatic logic [31:0] mtag(input logic [31:0] pc);
      return pc >> 8;
   endfunction

   function automatic logic m_pt(input logic [31:0] pc);
      int i = midx(pc);
      return m_ready && m_vld[i] && (m_tag[i] == mtag(pc)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
      return m_pt(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
   endfunction

   function automatic logic m_resolving();
      return m_ready && ex_valid && ex_is_branch;
   endfunction

   function automatic logic m_mp();
      if (!m_resolving()) return 1'b0;
      if (ex_taken != ex_pred_taken) return 1'b1;
      return ex_taken && (ex_pred_target != ex_target);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_started   = 1;
         m_ready     = 0;
         m_since_rst = 0;
         m_bcnt      = 0;
         m_mcnt      = 0;
      end else if (m_started && !m_ready) begin
         m_since_rst++;
         if (m_since_rst == ENT) begin
            for (int i = 0; i < ENT; i++) begin
               m_ctr[i] = 1;
               m_vld[i] = 0;
            end
            m_ready = 1;
         end
      end else if (m_started && m_resolving()) begin
         int i = midx(ex_pc);
         m_bcnt = m_bcnt + 1;
         if (m_mp()) m_mcnt = m_mcnt + 1;
         if (ex_taken) begin
            if (m_ctr[i] < 3) m_ctr[i]++;
            m_vld[i] = 1;
            m_tag[i] = mtag(ex_pc);
            m_tgt[i] = ex_target;
         end else begin
            if (m_ctr[i] > 0) m_ctr[i]--;
         end
      end
   end

   // Per-cycle compare on the inactive edge
   always @(negedge clk) begin
      if (m_started) begin
         chk("ready", {31'd0, ready}, {31'd0, m_ready});
         chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pt(fetch_pc)});
         chk("pred_target", pred_target, m_ptgt(fetch_pc));
         chk("mispredict", {31'd0, mispredict}, {31'd0, m_mp()});
         chk("redirect_pc", redirect_pc,
             (m_resolving() && ex_taken) ? ex_target : ex_pc + 32'd4);
         chk("branch_cnt", branch_cnt, m_bcnt);
         chk("mispredict_cnt", mispredict_cnt, m_mcnt);
      end
   end

   // Driver tasks
   task automatic idle();
      ex_valid       = 1'b0;
      ex_is_branch   = 1'b0;
      ex_pc          = 32'h0;
      ex_taken       = 1'b0;
      ex_target      = 32'h0;
      ex_pred_taken  = 1'b0;
      ex_pred_target = 32'h0;
   endtask

   task automatic fin();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
      ex_valid       = 1'b1;
      ex_is_branch   = 1'b1;
      ex_pc          = pc;
      ex_taken       = tk;
      ex_target      = tgt;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
      @(negedge clk);
   endtask

   task automatic br_auto(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      fetch_pc = pc;
      br(pc, tk, tgt, m_pt(pc), m_ptgt(pc));
   endtask

   task automatic look(input logic [31:0] pc);
      fetch_pc = pc;
      @(negedge clk);
   endtask

   task automatic wait_ready(inout int n);
      while (!ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      fetch_pc = 32'h100;
      idle();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Init window: updates ignored, ready rises after exactly 64 cycles
      br(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      chk("init_ready", {31'd0, ready}, 32'd0);
      chk("init_mispredict", {31'd0, mispredict}, 32'd0);
      chk("init_pred_target", pred_target, 32'h104);
      fin();
      n = 1;
      wait_ready(n);
      chk("init_cycles", n, 64);
      chk("init_branch_cnt", branch_cnt, 32'd0);

      // Training with same-cycle collision on 0x100
      br_auto(32'h100, 1'b1, 32'h80);
      chk("train1_mispredict", {31'd0, mispredict}, 32'd1);
      chk("train1_redirect", redirect_pc, 32'h80);
      chk("collision_pred_now", {31'd0, pred_taken}, 32'd0);
      fin();
      look(32'h100);
      chk("collision_pred_next", {31'd0, pred_taken}, 32'd1);
      fin();
      br_auto(32'h100, 1'b1, 32'h80);
      chk("train2_mispredict", {31'd0, mispredict}, 32'd0);
      fin();
      look(32'h100);
      chk("train_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("train_pred_target", pred_target, 32'h80);
      chk("train_mispredict_cnt", mispredict_cnt, 32'd1);
      chk("train_branch_cnt", branch_cnt, 32'd2);
      fin();

      // Saturation then two not-taken steps
      for (int k = 0; k < 5; k++) begin
         br_auto(32'h100, 1'b1, 32'h80);
         fin();
      end
      fetch_pc = 32'h100;
      br(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      chk("sat_nt_mispredict", {31'd0, mispredict}, 32'd1);
      chk("sat_nt_redirect", redirect_pc, 32'h104);
      fin();
      look(32'h100);
      chk("sat_still_taken", {31'd0, pred_taken}, 32'd1);
      fin();
      br_auto(32'h100, 1'b0, 32'h80);
      fin();
      look(32'h100);
      chk("sat_now_not_taken", {31'd0, pred_taken}, 32'd0);
      chk("sat_branch_cnt", branch_cnt, 32'd9);
      chk("sat_mispredict_cnt", mispredict_cnt, 32'd3);
      fin();

      // Aliasing: 0x100 and 0x200 share index 0
      br_auto(32'h100, 1'b1, 32'h80);
      fin();
      br_auto(32'h200, 1'b1, 32'h300);
      fin();
      look(32'h100);
      chk("alias_100_taken", {31'd0, pred_taken}, 32'd0);
      chk("alias_100_target", pred_target, 32'h104);
      fin();
      look(32'h200);
      chk("alias_200_taken", {31'd0, pred_taken}, 32'd1);
      chk("alias_200_target", pred_target, 32'h300);
      fin();

      // Wrong target
      br(32'h200, 1'b1, 32'h90, 1'b1, 32'h80);
      chk("wrongtgt_mispredict", {31'd0, mispredict}, 32'd1);
      chk("wrongtgt_redirect", redirect_pc, 32'h90);
      fin();
      look(32'h200);
      chk("wrongtgt_btb", pred_target, 32'h90);
      fin();

      // Invalid execute slot with branch flag set
      br(32'h200, 1'b0, 32'h0, 1'b1, 32'h90);
      ex_valid = 1'b0;
      #1;
      chk("invalid_mispredict", {31'd0, mispredict}, 32'd0);
      chk("invalid_redirect", redirect_pc, 32'h204);
      fin();
      look(32'h200);
      chk("invalid_branch_cnt", branch_cnt, 32'd12);
      chk("invalid_pred_kept", {31'd0, pred_taken}, 32'd1);
      fin();

      // PC wrap on fall-through
      look(32'hFFFF_FFFC);
      chk("wrap_pred_target", pred_target, 32'h0);
      fin();

      // Reset mid-operation
      fetch_pc = 32'h200;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_branch_cnt", branch_cnt, 32'd0);
      chk("rst_mispredict_cnt", mispredict_cnt, 32'd0);
      n = 0;
      wait_ready(n);
      chk("reinit_cycles", n, 64);
      look(32'h100);
      chk("reinit_100_not_taken", {31'd0, pred_taken}, 32'd0);
      fin();
      look(32'h200);
      chk("reinit_200_not_taken", {31'd0, pred_taken}, 32'd0);
      chk("reinit_200_target", pred_target, 32'h204);
      fin();

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and redirect generator for the RV32I pipeline.
- Fetch side: a combinational lookup on the fetch PC returns a taken/not-taken prediction and a predicted target.
- Execute side: consumes the branch comparator's resolved outcome (BranchTaken) and the resolved target, trains a 2-bit saturating-counter BHT and a direct-mapped BTB, and flags mispredicts with the corrected PC.
- After reset, a sequential init sweep clears the tables one entry per cycle.

Parameters:
- IDX_BITS, 6, log2 of table entries; 64 entries by default. Index = pc[IDX_BITS+1:2].
- TAG_BITS, 30-IDX_BITS, tag width; tag = pc[31:IDX_BITS+2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- fetch_pc  in  32  PC being fetched this cycle.
- pred_taken  out  1  prediction for fetch_pc.
- pred_target  out  32  predicted target; equals fetch_pc+4 when pred_taken=0.
- ex_valid  in  1  execute-stage instruction is valid (not bubble/flushed).
- ex_is_branch  in  1  execute instruction is a conditional branch.
- ex_pc  in  32  PC of the execute instruction.
- ex_taken  in  1  resolved outcome (BranchTaken from the comparator).
- ex_target  in  32  resolved taken target (pc+imm).
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_pred_target  in  32  predicted target carried down the pipe.
- mispredict  out  1  flush/redirect request.
- redirect_pc  out  32  correct next PC when mispredict=1.
- ready  out  1  tables initialised; predictions and updates enabled.
- branch_cnt  out  32  resolved branches since reset.
- mispredict_cnt  out  32  mispredicts since reset.

Behaviour:
- **Reset** (rst=1 at a rising edge):
  - FSM enters INIT with sweep index 0.
  - ready=0, branch_cnt=0, mispredict_cnt=0.
  - Table contents are not required to be cleared in that cycle.
  - rst asserted mid-INIT or mid-RUN restarts the sweep at 0.
- **INIT:**
  - Each cycle writes entry[idx]: counter=2'b01 (weakly not-taken), btb_valid=0.
  - idx increments; after writing entry 2^IDX_BITS-1, FSM goes to RUN and ready=1 on the next cycle.
  - Default timing: ready rises exactly 64 cycles after the first clock with rst low.
  - During INIT: pred_taken=0, pred_target=fetch_pc+4, mispredict=0, counters frozen, all ex_* updates ignored.
- **Lookup** (combinational, 0 latency):
  - hit = btb_valid[i] & (btb_tag[i]==fetch_pc tag).
  - pred_taken = ready & hit & counter[i][1].
  - pred_target = pred_taken ? btb_target[i] : fetch_pc+4.
  - Counter predicts taken with no BTB hit → not taken.
- **Resolve** (combinational, active only when ready & ex_valid & ex_is_branch; else mispredict=0):
  - mispredict = (ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_pred_target != ex_target).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - When not resolving, redirect_pc = ex_pc+4 (don't-care, but defined).
- **Update** (registered, at the clock edge under the same resolve condition):
  - Counter at ex_pc index: taken → +1 saturating at 2'b11; not taken → −1 saturating at 2'b00.
  - If ex_taken: btb_valid=1, btb_tag=ex_pc tag, btb_target=ex_target. This overwrites any aliasing entry.
  - If not taken: BTB untouched.
  - branch_cnt += 1; mispredict_cnt += mispredict. Both counters wrap modulo 2^32.
- **Read/write collision** (same cycle, fetch and update hit the same index): lookup returns the pre-update value; the new value is visible the next cycle. No bypass.
- **Arithmetic:** all PC arithmetic is 32-bit, wrapping. ex_pc/fetch_pc bits [1:0] are ignored for indexing.
- ex_is_branch=1 with ex_valid=0 → no update, no mispredict.

Test Plan:
- **Reset/init:** hold rst 3 cycles, release → ready=0 for 64 cycles then 1. During that window, ex branch with ex_taken=1, ex_pred_taken=0 → mispredict=0, branch_cnt stays 0.
- **Training:** branch at ex_pc=0x100, target 0x80, taken 2×, with ex_pred_taken matching pred_taken at each lookup. Expected:
  - first resolve: mispredict=1, redirect_pc=0x80;
  - afterwards, fetch_pc=0x100 → pred_taken=1, pred_target=0x80;
  - mispredict_cnt=1, branch_cnt=2.
- **Saturation:** 5 taken updates at 0x100, then 1 not-taken (ex_pred_taken=1) → mispredict=1, redirect_pc=0x104; pred_taken still 1 (counter 2'b10). A second not-taken → pred_taken=0.
- **Aliasing:** train 0x100 taken (target 0x80), then 0x200 taken (target 0x300, same index for IDX_BITS=6) → fetch_pc=0x100 yields pred_taken=0, pred_target=0x104 (tag miss); fetch_pc=0x200 yields target 0x300.
- **Wrong target:** ex_taken=1, ex_pred_taken=1, ex_pred_target=0x80, ex_target=0x90 → mispredict=1, redirect_pc=0x90; BTB target becomes 0x90.
- **Collision and reset mid-operation:** fetch_pc=ex_pc=0x100 in the same cycle as the first taken update → pred_taken=0 that cycle, 1 the next cycle (counter 2'b10). Then assert rst for 1 cycle → pred_taken=0, both counters read 0, ready=0 for 64 cycles, and 0x100 predicts not-taken after init.
